// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU writeback stage:
//   - 4-bit ALU opcode constants
//   - flag-update class enum and op_flag_class() decoder
//   - wb_entry_t, a register-file write record at the default widths
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int WB_DATA_W = 8;
    localparam int WB_ADDR_W = 3;

    // Shifts and rotates
    localparam logic [3:0] OP_SHL  = 4'b0000;
    localparam logic [3:0] OP_SHR  = 4'b0001;
    localparam logic [3:0] OP_ROL  = 4'b0010;
    localparam logic [3:0] OP_ROR  = 4'b0011;
    // Arithmetic
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_ADC  = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_SBC  = 4'b1011;
    // Logic
    localparam logic [3:0] OP_AND  = 4'b1100;
    localparam logic [3:0] OP_OR   = 4'b1101;
    localparam logic [3:0] OP_XOR  = 4'b1110;
    localparam logic [3:0] OP_ANDN = 4'b1111;

    // Which architectural flags an accepted result updates. Unassigned
    // opcodes (0100-0111) touch neither flag.
    typedef enum logic [1:0] {
        FLAGS_NONE = 2'd0,
        FLAGS_Z    = 2'd1,
        FLAGS_CZ   = 2'd2
    } flag_class_e;

    function automatic flag_class_e op_flag_class(input logic [3:0] op);
        flag_class_e cls;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC,
            OP_SHL, OP_SHR:                  cls = FLAGS_CZ;
            OP_AND, OP_OR, OP_XOR, OP_ANDN,
            OP_ROL, OP_ROR:                  cls = FLAGS_Z;
            default:                         cls = FLAGS_NONE;
        endcase
        return cls;
    endfunction

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/alu_writeback_stage_if.sv
// -----------------------------------------------------------------------------
// alu_writeback_stage_if
// Bundles the two handshake channels of the writeback stage:
//   ALU result channel : in_valid/in_ready, alu_result, alu_carry, alu_zero,
//                        alu_op, dest_reg, wr_req
//   Register-file port : rf_wr_valid/rf_wr_ready, rf_wr_addr, rf_wr_data
// Modports:
//   slave  - the writeback stage (consumes results, drives the write port)
//   master - the environment (ALU issues results, register file accepts writes)
// -----------------------------------------------------------------------------
interface alu_writeback_stage_if #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     alu_result;
    logic                  alu_carry;
    logic                  alu_zero;
    logic [3:0]            alu_op;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic                  wr_req;

    logic                  rf_wr_valid;
    logic                  rf_wr_ready;
    logic [REG_ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0]     rf_wr_data;

    modport slave (
        input  in_valid, alu_result, alu_carry, alu_zero, alu_op, dest_reg,
               wr_req, rf_wr_ready,
        output in_ready, rf_wr_valid, rf_wr_addr, rf_wr_data
    );

    modport master (
        output in_valid, alu_result, alu_carry, alu_zero, alu_op, dest_reg,
               wr_req, rf_wr_ready,
        input  in_ready, rf_wr_valid, rf_wr_addr, rf_wr_data
    );
endinterface

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// DEPTH-entry synchronous FIFO of register-file writes {addr, data}.
// DEPTH must be a power of two (2..8) so the pointers wrap naturally.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_addr/data enqueue at the tail (caller guarantees !full)
//   pop                 dequeue at the head (caller guarantees !empty)
//   head_addr/data      head entry contents
//   count, full, empty  occupancy
//   entry_valid[i]      slot i currently holds a queued write
//   entry_addr[i]       destination stored in slot i
// -----------------------------------------------------------------------------
module wb_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic [DEPTH-1:0]  entry_valid,
    output logic [ADDR_W-1:0] entry_addr [DEPTH]
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // NOTE: the storage array has no reset; entry_valid/count decide which
    // slots mean anything, so stale contents are never observed as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{addr: push_addr, data: push_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            // A slot is never pushed and popped in the same cycle: that would
            // need head == tail with the FIFO both empty and non-empty.
            if (push) begin
                tail              <= tail + PTR_W'(1);
                entry_valid[tail] <= 1'b1;
            end
            if (pop) begin
                head              <= head + PTR_W'(1);
                entry_valid[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_addr = mem[head].addr;
    assign head_data = mem[head].data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_addr
        assign entry_addr[i] = mem[i].addr;
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// -----------------------------------------------------------------------------
// alu_writeback_stage
// Downstream stage of the 8-bit ALU: captures each result, maintains the
// architectural carry/zero flags and queues register-file writes in a small
// FIFO drained through a valid/ready write port.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   bus (slave)    ALU result channel + register-file write port
//   carry_flag     architectural C (feeds ALU carryIn)
//   zero_flag      architectural Z
//   pending_mask   bit r set while any queued write targets register r
// Build option:
//   ALU_WB_BYPASS_EN  when defined, a write accepted while the FIFO is empty
//                     is presented on the write port in the same cycle and
//                     skips the FIFO if the register file takes it at once.
// -----------------------------------------------------------------------------
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int DEPTH      = 2,
    localparam int NUM_REGS  = 2 ** REG_ADDR_W,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    alu_writeback_stage_if.slave bus,
    output logic                carry_flag,
    output logic                zero_flag,
    output logic [NUM_REGS-1:0] pending_mask
);

    logic                  in_ready;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  rf_wr_valid;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0]     head_data;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic [DEPTH-1:0]      entry_valid;
    logic [REG_ADDR_W-1:0] entry_addr [DEPTH];

    // Registered occupancy only: in_ready never looks at rf_wr_ready, so a
    // full FIFO refuses input even in a cycle where it also drains.
    assign in_ready = (count != CNT_W'(DEPTH)) && !rst;
    assign accept   = bus.in_valid && in_ready;

`ifdef ALU_WB_BYPASS_EN
    logic bypass;

    assign bypass      = empty && accept && bus.wr_req;
    assign rf_wr_valid = (!empty && !rst) || bypass;
    assign pop         = !empty && !rst && bus.rf_wr_ready;
    // A bypassed write taken immediately never occupies a slot.
    assign push        = accept && bus.wr_req && !full
                         && !(bypass && bus.rf_wr_ready);
    assign bus.rf_wr_addr = empty ? bus.dest_reg   : head_addr;
    assign bus.rf_wr_data = empty ? bus.alu_result : head_data;
`else
    assign rf_wr_valid = !empty && !rst;
    assign pop         = rf_wr_valid && bus.rf_wr_ready;
    assign push        = accept && bus.wr_req && !full;
    assign bus.rf_wr_addr = head_addr;
    assign bus.rf_wr_data = head_data;
`endif

    assign bus.in_ready    = in_ready;
    assign bus.rf_wr_valid = rf_wr_valid;

    wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (REG_ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (bus.dest_reg),
        .push_data   (bus.alu_result),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // Flags follow every accepted result, including flags-only (wr_req=0)
    // compares; a stalled result leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else if (accept) begin
            case (op_flag_class(bus.alu_op))
                FLAGS_CZ: begin
                    carry_flag <= bus.alu_carry;
                    zero_flag  <= bus.alu_zero;
                end
                FLAGS_Z: begin
                    zero_flag  <= bus.alu_zero;
                end
                default: ;
            endcase
        end
    end

    // NOTE: pending_mask gets a full default before the loop so no bit is
    // left unassigned on any path, which would otherwise infer a latch.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending_mask[entry_addr[i]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_writeback_stage
// Table of per-cycle rows {inputs, expected flags after the edge}; a queue of
// expected register-file writes is filled as rows are accepted and drained as
// the write port fires.
// -----------------------------------------------------------------------------
module tb_alu_writeback_stage;
    import alu_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    logic carry_flag;
    logic zero_flag;
    logic [7:0] pending_mask;

    int checks   = 0;
    int failures = 0;

    wb_entry_t sb [$];

    alu_writeback_stage_if #(.DATA_W(8), .REG_ADDR_W(3)) bus ();

    alu_writeback_stage #(
        .DATA_W     (8),
        .REG_ADDR_W (3),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .carry_flag   (carry_flag),
        .zero_flag    (zero_flag),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] op;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic [2:0] dest;
        logic       wr;
        logic       rdy;
        logic       exp_c;
        logic       exp_z;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic r, input logic iv,
                                input logic [3:0] op, input logic [7:0] res,
                                input logic c, input logic z,
                                input logic [2:0] d, input logic wr,
                                input logic rdy, input logic ec,
                                input logic ez);
        vec_t v;
        v.rst = r;  v.iv = iv; v.op = op; v.res = res; v.c = c; v.z = z;
        v.dest = d; v.wr = wr; v.rdy = rdy; v.exp_c = ec; v.exp_z = ez;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one row, check combinational outputs mid-cycle, then update the
    // expected-write queue at the edge and check the flags just after it.
    task automatic run_row(input int idx, input vec_t v);
        logic      exp_ready;
        logic      acc;
        logic      byp;
        logic      exp_valid;
        logic [7:0] exp_mask;
        wb_entry_t head;

        rst             = v.rst;
        bus.in_valid    = v.iv;
        bus.alu_op      = v.op;
        bus.alu_result  = v.res;
        bus.alu_carry   = v.c;
        bus.alu_zero    = v.z;
        bus.dest_reg    = v.dest;
        bus.wr_req      = v.wr;
        bus.rf_wr_ready = v.rdy;

        @(negedge clk);
        exp_ready = !v.rst && (sb.size() < DEPTH);
        acc       = v.iv && exp_ready;
        byp       = 1'b0;
`ifdef ALU_WB_BYPASS_EN
        byp       = (sb.size() == 0) && acc && v.wr;
`endif
        exp_valid = !v.rst && ((sb.size() != 0) || byp);

        check($sformatf("row%0d in_ready", idx), 32'(bus.in_ready), 32'(exp_ready));
        check($sformatf("row%0d rf_wr_valid", idx), 32'(bus.rf_wr_valid), 32'(exp_valid));
        if (exp_valid) begin
            if (byp) head = '{addr: v.dest, data: v.res};
            else     head = sb[0];
            check($sformatf("row%0d rf_wr_addr", idx), 32'(bus.rf_wr_addr), 32'(head.addr));
            check($sformatf("row%0d rf_wr_data", idx), 32'(bus.rf_wr_data), 32'(head.data));
        end
        if (!v.rst) begin
            exp_mask = '0;
            foreach (sb[i]) exp_mask[sb[i].addr] = 1'b1;
            check($sformatf("row%0d pending_mask", idx), 32'(pending_mask), 32'(exp_mask));
        end

        @(posedge clk);
        if (v.rst) begin
            sb.delete();
        end else begin
            if (exp_valid && v.rdy && !byp) void'(sb.pop_front());
            if (acc && v.wr && !(byp && v.rdy))
                sb.push_back('{addr: v.dest, data: v.res});
        end
        #1;
        check($sformatf("row%0d carry_flag", idx), 32'(carry_flag), 32'(v.exp_c));
        check($sformatf("row%0d zero_flag", idx), 32'(zero_flag), 32'(v.exp_z));
    endtask

    initial begin
        //             rst iv op       res    c  z  dst wr rdy  C  Z
        // reset, then reset state
        vecs.push_back(mk(1, 0, OP_ADD,  8'h00, 0, 0, 0, 0, 1,  0, 0));
        vecs.push_back(mk(0, 0, OP_ADD,  8'h00, 0, 0, 0, 0, 1,  0, 0));
        // ADD -> C=1 Z=1, write r3; then AND holds C, clears Z
        vecs.push_back(mk(0, 1, OP_ADD,  8'h00, 1, 1, 3, 1, 1,  1, 1));
        vecs.push_back(mk(0, 1, OP_AND,  8'h5A, 0, 0, 1, 1, 1,  1, 0));
        vecs.push_back(mk(0, 0, OP_ADD,  8'h00, 0, 0, 0, 0, 1,  1, 0));
        vecs.push_back(mk(0, 0, OP_ADD,  8'h00, 0, 0, 0, 0, 1,  1, 0));
        // stalled port: two writes fill the FIFO, third is held upstream
        vecs.push_back(mk(0, 1, OP_ADC,  8'h11, 0, 0, 2, 1, 0,  0, 0));
        vecs.push_back(mk(0, 1, OP_SUB,  8'h22, 1, 0, 4, 1, 0,  1, 0));
        vecs.push_back(mk(0, 1, OP_XOR,  8'h00, 0, 1, 6, 1, 0,  1, 0));
        // full + ready: dequeue only; next cycle dequeue and enqueue
        vecs.push_back(mk(0, 1, OP_XOR,  8'h00, 0, 1, 6, 1, 1,  1, 0));
        vecs.push_back(mk(0, 1, OP_XOR,  8'h00, 0, 1, 6, 1, 1,  1, 1));
        vecs.push_back(mk(0, 0, OP_ADD,  8'h00, 0, 0, 0, 0, 1,  1, 1));
        // flags-only compare leaves the queue and mask alone
        vecs.push_back(mk(0, 1, OP_SHL,  8'h80, 1, 0, 5, 1, 0,  1, 0));
        vecs.push_back(mk(0, 1, OP_SUB,  8'h00, 0, 1, 7, 0, 0,  0, 1));
        vecs.push_back(mk(0, 1, OP_ROL,  8'h01, 0, 0, 5, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0, OP_ADD,  8'h00, 0, 0, 0, 0, 0,  0, 0));
        // reset with two writes to r5 queued: all discarded
        vecs.push_back(mk(1, 0, OP_ADD,  8'h00, 0, 0, 0, 0, 0,  0, 0));
        vecs.push_back(mk(0, 0, OP_ADD,  8'h00, 0, 0, 0, 0, 1,  0, 0));
        // shifts/rotates and duplicate destination ordering
        vecs.push_back(mk(0, 1, OP_SHR,  8'h00, 1, 1, 0, 1, 1,  1, 1));
        vecs.push_back(mk(0, 1, OP_ROR,  8'h7F, 0, 0, 0, 1, 1,  1, 0));
        vecs.push_back(mk(0, 1, OP_SBC,  8'hFF, 0, 0, 7, 1, 1,  0, 0));
        vecs.push_back(mk(0, 0, OP_ADD,  8'h00, 0, 0, 0, 0, 1,  0, 0));
        vecs.push_back(mk(0, 0, OP_ADD,  8'h00, 0, 0, 0, 0, 1,  0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_row(i, vecs[i]);
        end

        check("final queue drained", 32'(bus.rf_wr_valid), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
Downstream stage of the 8-bit ALU. Captures each ALU result with its carryOut/zero outputs, maintains the architectural carry and zero flags, and queues register-file writes in a small FIFO that drains through a valid/ready write port. The carry flag feeds back to the ALU carryIn. A pending-destination mask lets the issue logic detect read-after-write hazards.

Parameters:
DATA_W, 8, ALU result width
REG_ADDR_W, 3, register-file address width (2**REG_ADDR_W registers)
DEPTH, 2, write FIFO entries; power of two, 2..8

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  ALU result presented this cycle
in_ready  output  1  stage can accept; in_ready = (count != DEPTH) && !rst
alu_result  input  DATA_W  ALU result
alu_carry  input  1  ALU carryOut
alu_zero  input  1  ALU zero
alu_op  input  4  ALU operation code for this result
dest_reg  input  REG_ADDR_W  destination register
wr_req  input  1  1 = result is written to dest_reg; 0 = flags-only (compare-style)
rf_wr_valid  output  1  head FIFO entry is valid
rf_wr_ready  input  1  register file accepts the write
rf_wr_addr  output  REG_ADDR_W  head entry address
rf_wr_data  output  DATA_W  head entry data
carry_flag  output  1  architectural C; wired to ALU carryIn
zero_flag  output  1  architectural Z
pending_mask  output  2**REG_ADDR_W  bit r set while any FIFO entry targets register r

Behaviour:
- Reset: count=0, head/tail pointers=0, carry_flag=0, zero_flag=0, rf_wr_valid=0, pending_mask=0. Reset mid-drain discards every queued write.
- An entry is accepted when in_valid && in_ready.
- Flag update on accept, visible the next cycle:
  - ops 1000–1011 (add/adc/sub/sbc): C <= alu_carry, Z <= alu_zero.
  - ops 1100–1111 (logic): Z only; C is held.
  - ops 0000/0001 (shl/shr): C and Z.
  - ops 0010/0011 (rotates): Z only.
- Flag updates happen regardless of wr_req.
- Accepted entries with wr_req=0 are not enqueued.
- FIFO:
  - Enqueue at the tail; dequeue at the head on rf_wr_valid && rf_wr_ready.
  - Pointers wrap modulo DEPTH.
  - Enqueue and dequeue in the same cycle leaves count unchanged. This is legal at any count below DEPTH.
  - When full, in_ready=0, so there is no enqueue even if a dequeue occurs that cycle. in_ready must not depend combinationally on rf_wr_ready.
- Empty: rf_wr_valid=0. rf_wr_addr/rf_wr_data hold their last values (do-not-care).
- Latency: result accepted at cycle N appears on the write port at N+1 at the earliest.
- Ordering: writes leave in acceptance order, including duplicate destinations.
- pending_mask:
  - Recomputed from the registered FIFO contents each cycle (combinational over the valid entries).
  - A register stays marked until its last queued write dequeues.
- in_valid while in_ready=0: ignored; upstream must hold the entry.

Optional Feature:
ALU_WB_BYPASS_EN:
- Defined: when the FIFO is empty and an accepted entry has wr_req=1, it is driven onto the write port in the same cycle (rf_wr_valid=1, combinational from inputs).
  - If rf_wr_ready=1, it is not enqueued; zero-latency write.
  - Otherwise it is enqueued normally.
- Undefined: minimum latency is 1 cycle; write-port outputs are purely registered/FIFO-derived.

Decomposition:
- Package alu_pkg:
  - 4-bit opcode constants: OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_XOR, OP_ANDN, OP_SHL, OP_SHR, OP_ROL, OP_ROR.
  - Flag-update enum FLAGS_CZ / FLAGS_Z.
  - Function op_flag_class(op) returning that enum.
  - Struct wb_entry_t {addr, data}.
- One sub-module, wb_fifo: parameterised DEPTH-entry synchronous FIFO with count, full/empty and per-entry valid vector for pending_mask.

Test Plan:
- Reset then ADD result 8'h00, carry=1, zero=1, dest=3, wr_req=1, rf_wr_ready=1 -> next cycle carry_flag=1, zero_flag=1, rf_wr_valid=1, addr=3, data=8'h00, pending_mask=8'b0000_1000; mask clears the cycle after the write.
- AND (1100) result 8'h5A, carry=0 after C=1 -> carry_flag stays 1, zero_flag=0.
- rf_wr_ready=0, accept three writes -> in_ready=0 after the second (DEPTH=2); the third is held upstream. Release ready -> data drains in order, 1 per cycle.
- FIFO full, then rf_wr_ready=1 with in_valid=1 -> dequeue only that cycle; enqueue the next cycle; count never exceeds 2.
- CMP-style SUB, wr_req=0, result 8'h00 -> zero_flag=1, no write, pending_mask unchanged.
- Two queued writes to reg 5, assert rst for one cycle -> rf_wr_valid=0, pending_mask=0, flags=0, no write issued.
